// File: rtl/rc4_ksa_core.sv
// RC4 key-scheduling core: initialises S[0..255] in an external byte memory, then runs the KSA swap loop.
// Optional build macro KSA_ITER_LIMIT_EN adds an iter_limit port that caps the number of shuffle iterations.
module rc4_ksa_core #(
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_wren,
    input  logic [7:0]             mem_rdata,
    output logic [7:0]             dbg_j
`ifdef KSA_ITER_LIMIT_EN
    ,
    input  logic [8:0]             iter_limit
`endif
);
    localparam int              KW    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0]   KLAST = KW'(KEY_BYTES - 1);
    localparam logic            WLAST = 1'(RD_LAT - 1);

    typedef enum logic [3:0] {
        IDLE, INIT, RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, WR_I, WR_J, DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               i_q, i_d, j_q, j_d;
    logic [7:0]               si_q, si_d, sj_q, sj_d;
    logic [KW-1:0]            kidx_q, kidx_d;
    logic                     wcnt_q, wcnt_d;
    logic [8*KEY_BYTES-1:0]   key_q, key_d;
    logic [7:0]               kbyte;
    logic                     last_iter, zero_iter;

`ifdef KSA_ITER_LIMIT_EN
    logic [8:0] lim_q, lim_d;
    // i_q+1 is the number of iterations finished once WR_J completes
    assign last_iter = (i_q == 8'hFF) || (({1'b0, i_q} + 9'd1) >= lim_q);
    assign zero_iter = (lim_q == 9'd0);
`else
    assign last_iter = (i_q == 8'hFF);
    assign zero_iter = 1'b0;
`endif

    // Byte 0 of the key sits in the most significant byte lane
    always_comb begin
        kbyte = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++)
            if (kidx_q == KW'(b)) kbyte = key_q[8*(KEY_BYTES-1-b) +: 8];
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        kidx_d    = kidx_q;
        wcnt_d    = wcnt_q;
        key_d     = key_q;
`ifdef KSA_ITER_LIMIT_EN
        lim_d     = lim_q;
`endif
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        mem_wren  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                key_d   = key;
                i_d     = 8'h00;
                j_d     = 8'h00;
                kidx_d  = '0;
`ifdef KSA_ITER_LIMIT_EN
                lim_d   = iter_limit;
`endif
                state_d = INIT;
            end
            INIT: begin
                mem_addr  = i_q;
                mem_wdata = i_q;
                mem_wren  = 1'b1;
                i_d       = i_q + 8'd1;
                if (i_q == 8'hFF) state_d = zero_iter ? DONE : RD_I;
            end
            RD_I: begin
                mem_addr = i_q;
                wcnt_d   = 1'b0;
                state_d  = WAIT_I;
            end
            WAIT_I: begin
                mem_addr = i_q;
                if (wcnt_q == WLAST) begin
                    si_d    = mem_rdata;
                    state_d = CALC_J;
                end else begin
                    wcnt_d  = 1'b1;
                end
            end
            CALC_J: begin
                j_d     = j_q + si_q + kbyte;
                kidx_d  = (kidx_q == KLAST) ? '0 : kidx_q + 1'b1;
                state_d = RD_J;
            end
            RD_J: begin
                mem_addr = j_q;
                wcnt_d   = 1'b0;
                state_d  = WAIT_J;
            end
            WAIT_J: begin
                mem_addr = j_q;
                if (wcnt_q == WLAST) begin
                    sj_d    = mem_rdata;
                    state_d = WR_I;
                end else begin
                    wcnt_d  = 1'b1;
                end
            end
            WR_I: begin
                mem_addr  = i_q;
                mem_wdata = sj_q;
                mem_wren  = 1'b1;
                state_d   = WR_J;
            end
            WR_J: begin
                mem_addr  = j_q;
                mem_wdata = si_q;
                mem_wren  = 1'b1;
                i_d       = i_q + 8'd1;
                state_d   = last_iter ? DONE : RD_I;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 8'h00;
            j_q     <= 8'h00;
            si_q    <= 8'h00;
            sj_q    <= 8'h00;
            kidx_q  <= '0;
            wcnt_q  <= 1'b0;
            key_q   <= '0;
`ifdef KSA_ITER_LIMIT_EN
            lim_q   <= 9'd0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            wcnt_q  <= wcnt_d;
            key_q   <= key_d;
`ifdef KSA_ITER_LIMIT_EN
            lim_q   <= lim_d;
`endif
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign dbg_j = j_q;

endmodule

// File: tb/tb_rc4_ksa_core.sv
// Bench for rc4_ksa_core: two instances (3-byte key / 1-cycle memory, 1-byte key / 2-cycle memory)
// checked against a plain software RC4 KSA model; iter_limit scenarios build only with KSA_ITER_LIMIT_EN.
module tb_rc4_ksa_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   errors = 0;
    int   checks = 0;

    // Instance A: KEY_BYTES=3, RD_LAT=1
    logic        start_a, busy_a, done_a, wren_a;
    logic [23:0] key_a;
    logic [7:0]  addr_a, wdata_a, rdata_a, dbg_a;
    logic [7:0]  mem_a [256];
    // Instance B: KEY_BYTES=1, RD_LAT=2
    logic        start_b, busy_b, done_b, wren_b;
    logic [7:0]  key_b;
    logic [7:0]  addr_b, wdata_b, rdata_b, rd_b1, dbg_b;
    logic [7:0]  mem_b [256];
`ifdef KSA_ITER_LIMIT_EN
    logic [8:0]  lim_a, lim_b;
`endif

    rc4_ksa_core #(.KEY_BYTES(3), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .key(key_a), .busy(busy_a), .done(done_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wren(wren_a), .mem_rdata(rdata_a), .dbg_j(dbg_a)
`ifdef KSA_ITER_LIMIT_EN
        , .iter_limit(lim_a)
`endif
    );

    rc4_ksa_core #(.KEY_BYTES(1), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key(key_b), .busy(busy_b), .done(done_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wren(wren_b), .mem_rdata(rdata_b), .dbg_j(dbg_b)
`ifdef KSA_ITER_LIMIT_EN
        , .iter_limit(lim_b)
`endif
    );

    // Byte memories with 1- and 2-cycle registered reads
    always @(posedge clk) begin
        if (wren_a) mem_a[addr_a] <= wdata_a;
        rdata_a <= mem_a[addr_a];
        if (wren_b) mem_b[addr_b] <= wdata_b;
        rd_b1   <= mem_b[addr_b];
        rdata_b <= rd_b1;
    end

    logic       sel;
    logic       o_busy, o_done, o_wren;
    logic [7:0] o_addr, o_wdata, o_dbg;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_wren  = sel ? wren_b  : wren_a;
    assign o_addr  = sel ? addr_b  : addr_a;
    assign o_wdata = sel ? wdata_b : wdata_a;
    assign o_dbg   = sel ? dbg_b   : dbg_a;

    // Reference: textbook RC4 KSA on an array
    logic [7:0] ms [256];
    logic [7:0] mj;
    task automatic model_ksa(input logic [255:0] k, input int n, input int iters);
        logic [7:0] kb, t;
        for (int a = 0; a < 256; a++) ms[a] = 8'(a);
        mj = 8'h00;
        for (int i = 0; i < iters; i++) begin
            kb     = k[8*(n-1-(i % n)) +: 8];
            mj     = mj + ms[i] + kb;
            t      = ms[i];
            ms[i]  = ms[mj];
            ms[mj] = t;
        end
    endtask

    task automatic run_ksa(input bit b, input logic [23:0] k, input int lim, input int stray_at,
                           input string nm);
        int n, per, iters, exp_cyc, cyc;
        bit seen;
        logic [7:0] mv;
        n = b ? 1 : 3;
        per = b ? 9 : 7;
        iters = 256;
`ifdef KSA_ITER_LIMIT_EN
        iters = (lim < 256) ? lim : 256;
`endif
        exp_cyc = 257 + iters * per;
        model_ksa({232'd0, k}, n, iters);
        sel = b;
        @(posedge clk); #1;
        if (b) begin start_b = 1'b1; key_b = k[7:0]; end
        else   begin start_a = 1'b1; key_a = k; end
`ifdef KSA_ITER_LIMIT_EN
        lim_a = 9'(lim);
        lim_b = 9'(lim);
`endif
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            start_a = !b && (cyc == stray_at);
            start_b = b && (cyc == stray_at);
            key_a = 24'($urandom);
            key_b = 8'($urandom);
`ifdef KSA_ITER_LIMIT_EN
            lim_a = 9'($urandom);
            lim_b = 9'($urandom);
`endif
            if (cyc == 1) begin
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_start: got %b expected 1", nm, o_busy);
                end
            end
            if (o_done === 1'b1) seen = 1'b1;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        checks++;
        if (!seen || cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s done_latency: got %0d (seen=%0b) expected %0d", nm, cyc, seen, exp_cyc);
        end
        if (seen) begin
            checks++;
            if (o_addr !== 8'h00 || o_wdata !== 8'h00 || o_wren !== 1'b0 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s done_cycle_outputs: got addr=%h wdata=%h wren=%b busy=%b expected 00 00 0 1",
                         nm, o_addr, o_wdata, o_wren, o_busy);
            end
            checks++;
            if (o_dbg !== mj) begin
                errors++;
                $display("FAIL %s final_j: got %h expected %h", nm, o_dbg, mj);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", nm, o_done, o_busy);
        end
        for (int a = 0; a < 256; a++) begin
            mv = b ? mem_b[a] : mem_a[a];
            checks++;
            if (mv !== ms[a]) begin
                errors++;
                $display("FAIL %s S[%0d]: got %h expected %h", nm, a, mv, ms[a]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a, wren_a, addr_a, wdata_a, dbg_a} !== 27'd0) begin
            errors++;
            $display("FAIL reset_a: got busy=%b done=%b wren=%b addr=%h wdata=%h j=%h expected all 0",
                     busy_a, done_a, wren_a, addr_a, wdata_a, dbg_a);
        end
        checks++;
        if ({busy_b, done_b, wren_b, addr_b, wdata_b, dbg_b} !== 27'd0) begin
            errors++;
            $display("FAIL reset_b: got busy=%b done=%b wren=%b addr=%h wdata=%h j=%h expected all 0",
                     busy_b, done_b, wren_b, addr_b, wdata_b, dbg_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_known_key;
        run_ksa(1'b0, 24'h000249, 256, -1, "key000249_lat1");
    endtask

    task automatic test_random_keys;
        for (int r = 0; r < 3; r++) run_ksa(1'b0, 24'($urandom), 256, -1, "rand_lat1");
        run_ksa(1'b1, 24'h000000, 256, -1, "key00_lat2");
        run_ksa(1'b1, 24'($urandom_range(255, 1)), 256, -1, "rand_lat2");
    endtask

    task automatic test_back_to_back;
        run_ksa(1'b0, 24'h000249, 256, 1000, "stray_start");
        run_ksa(1'b0, 24'($urandom), 256, 10, "stray_start_early");
    endtask

    task automatic test_reset_midrun;
        int cyc;
        sel = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b1;
        key_a = 24'h000249;
        cyc = 0;
        while (cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            start_a = 1'b0;
        end
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy: got %b expected 1", busy_a);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy_a, done_a, wren_a, addr_a, wdata_a, dbg_a} !== 27'd0) begin
            errors++;
            $display("FAIL midrun_reset: got busy=%b done=%b wren=%b addr=%h wdata=%h j=%h expected all 0",
                     busy_a, done_a, wren_a, addr_a, wdata_a, dbg_a);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_a !== 1'b0 || wren_a !== 1'b0) begin
            errors++;
            $display("FAIL midrun_idle: got busy=%b wren=%b expected 0 0", busy_a, wren_a);
        end
        run_ksa(1'b0, 24'h000249, 256, -1, "after_reset");
    endtask

`ifdef KSA_ITER_LIMIT_EN
    task automatic test_iter_limit;
        run_ksa(1'b0, 24'h000249, 2, -1, "limit2");
        checks++;
        if (mem_a[1] !== 8'h03 || mem_a[3] !== 8'h01 || dbg_a !== 8'h03) begin
            errors++;
            $display("FAIL limit2_values: got S1=%h S3=%h j=%h expected 03 01 03", mem_a[1], mem_a[3], dbg_a);
        end
        run_ksa(1'b0, 24'($urandom), 0, -1, "limit0");
        run_ksa(1'b1, 24'($urandom), 300, -1, "limit300");
        run_ksa(1'b1, 24'($urandom), 17, -1, "limit17");
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        key_a = 24'h0;
        key_b = 8'h0;
`ifdef KSA_ITER_LIMIT_EN
        lim_a = 9'd0;
        lim_b = 9'd0;
`endif
        test_reset();
        test_known_key();
        test_random_keys();
        test_back_to_back();
        test_reset_midrun();
`ifdef KSA_ITER_LIMIT_EN
        test_iter_limit();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
